// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection encodings and the
// master bridge state enum.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  // Read data returned to the core when the watchdog aborts a transaction.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } bridge_state_e;

endpackage

// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite bus bundle between the master bridge and the downstream
// interconnect; the master modport is the bridge side.
interface axi4_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;

    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;

    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;

    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Core request port to AXI4-Lite master, one transaction outstanding.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic                    cpu_instr,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_ready,
    output logic                    cpu_done,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_err,

    axi4_lite_master_bridge_if.master m_axi
);

    bridge_state_e           state_q;
    logic                    ready_q, done_q, err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [2:0]              arprot_q;
    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                    aw_done_q, w_done_q;

    logic aw_hs, w_hs, timeout;

    assign aw_hs = awvalid_q && m_axi.M_AXI_AWREADY;
    assign w_hs  = wvalid_q  && m_axi.M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
    // Responses arriving after an abort are sunk while idle.
    localparam logic IDLE_READY = 1'b1;
    localparam int   CNT_W      = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    assign timeout = (state_q != ST_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    localparam logic IDLE_READY = 1'b0;

    assign timeout = 1'b0;
`endif

    // NOTE: every register here, control and datapath alike, is cleared by the
    // async reset and updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arprot_q  <= PROT_DATA;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (timeout) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                bready_q  <= IDLE_READY;
                rready_q  <= IDLE_READY;
                ready_q   <= 1'b1;
                done_q    <= 1'b1;
                err_q     <= 1'b1;
                rdata_q   <= DATA_WIDTH'(TIMEOUT_RDATA);
                state_q   <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        bready_q <= IDLE_READY;
                        rready_q <= IDLE_READY;
                        if (cpu_req) begin
                            addr_q   <= cpu_addr;
                            wdata_q  <= cpu_wdata;
                            wstrb_q  <= cpu_wstrb;
                            arprot_q <= cpu_instr ? PROT_INSTR : PROT_DATA;
                            ready_q  <= 1'b0;
                            bready_q <= 1'b0;
                            rready_q <= 1'b0;
                            if (cpu_we) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                                state_q   <= ST_WR_REQ;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_WR_REQ: begin
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end
                        // Either channel may finish last, possibly in this very cycle.
                        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end
                    ST_WR_RESP: begin
                        if (m_axi.M_AXI_BVALID) begin
                            bready_q <= IDLE_READY;
                            rready_q <= IDLE_READY;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                            err_q    <= (m_axi.M_AXI_BRESP != RESP_OKAY);
                            state_q  <= ST_IDLE;
                        end
                    end
                    ST_RD_REQ: begin
                        if (m_axi.M_AXI_ARREADY) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= ST_RD_RESP;
                        end
                    end
                    ST_RD_RESP: begin
                        if (m_axi.M_AXI_RVALID) begin
                            bready_q <= IDLE_READY;
                            rready_q <= IDLE_READY;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                            rdata_q  <= m_axi.M_AXI_RDATA;
                            err_q    <= (m_axi.M_AXI_RRESP != RESP_OKAY);
                            state_q  <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cpu_ready = ready_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWPROT  = PROT_DATA;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARPROT  = arprot_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule
